pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
- Central pipeline control unit for the 5-stage MIPS core.
- Resolves per-stage stall requests into the 6-bit stall vector consumed by all pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Sequences exception flushes, deferring a flush while the MEM-stage AXI-Lite data transaction is outstanding.
- Flags runaway stalls with a watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024, consecutive cycles with stall[0]=1 before stall_timeout is set (range 1..65535).
- RESET_PC, 32'hBFC00000, value of new_pc after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stallreq_if  in  1  IF stage busy (AXI-Lite instruction fetch outstanding).
- stallreq_id  in  1  ID stage load-use hazard.
- stallreq_ex  in  1  EX stage multi-cycle op (div/madd) busy.
- stallreq_mem  in  1  MEM stage AXI-Lite data access outstanding.
- excp_valid  in  1  exception detected on the instruction in MEM.
- excp_target  in  32  handler/return address for that exception.
- stall  out  6  bit0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB, 5=WB; 1 = STOP.
- flush  out  1  clears all pipeline registers; one-cycle pulse.
- new_pc  out  32  redirect address, valid while flush=1.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst=1): state=RUN, stall=6'b000000, flush=0, new_pc=RESET_PC, stall_timeout=0, watchdog counter=0, latched target=0.

Stall priority in RUN (combinational, highest stage wins):
- stallreq_mem -> 6'b011111
- stallreq_ex -> 6'b001111
- stallreq_id -> 6'b000111
- stallreq_if -> 6'b000011
- none -> 6'b000000

FSM states RUN, PEND, FLUSH; state registered on posedge clk.
- RUN, excp_valid=1, stallreq_mem=0: latch excp_target; next state FLUSH.
- RUN, excp_valid=1, stallreq_mem=1: latch excp_target; next state PEND. stall follows the priority table this cycle (= 6'b011111).
- PEND: stall forced to 6'b011111. excp_valid is ignored; the first exception wins. Exit to FLUSH in the cycle after stallreq_mem is sampled 0.
- FLUSH: flush=1, new_pc=latched target, stall=6'b000000. All requests and excp_valid are ignored. Next state is always RUN.
- flush and new_pc are registered Moore outputs. Latency from excp_valid (no mem stall) to flush is exactly 1 cycle.
- new_pc holds its last value after flush drops.
- flush is never asserted on back-to-back cycles.

Watchdog:
- 16-bit counter increments each cycle stall[0]=1, saturating at TIMEOUT_CYCLES; clears to 0 in any cycle stall[0]=0.
- stall_timeout sets when the counter reaches TIMEOUT_CYCLES and stays set until rst.

Boundaries:
- stallreq_mem dropping in the same cycle excp_valid rises is treated as the RUN/no-stall case.
- rst asserted in PEND or FLUSH returns immediately to the reset values; the pending exception is discarded.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined: adds output port stall_cycles (out, 32). It counts total cycles with stall[0]=1 since reset, wraps at 2^32, is not cleared by flush, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, all requests 0 -> stall=000000, flush=0, new_pc=32'hBFC00000, stall_timeout=0.
- stallreq_id=1 and stallreq_mem=1 in the same cycle -> stall=011111. Drop mem only -> stall=000111 in that cycle.
- excp_valid=1, excp_target=32'hBFC00380, no stalls -> next cycle flush=1, new_pc=32'hBFC00380, stall=000000. The cycle after -> flush=0, state RUN.
- excp_valid=1 with stallreq_mem=1 held 3 cycles, second excp_valid with 32'h0 during PEND -> stall=011111 for those cycles. flush pulses 1 cycle after stallreq_mem falls, with new_pc=32'hBFC00380.
- TIMEOUT_CYCLES=8, stallreq_if held 8 cycles -> stall_timeout rises on the 8th stalled cycle and remains 1 after the request drops. A 7-cycle stall, one free cycle, then a 7-cycle stall -> stall_timeout stays 0.
- rst pulsed mid-PEND -> outputs return to reset values asynchronously, and no flush follows.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush control: priority stall vector (comb), exception flush 1 cycle after excp_valid (deferred while MEM busy), sticky watchdog.
// STALL_PERF_CNT_EN adds the stall_cycles counter port.
module pipe_stall_ctrl #(
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    parameter logic [31:0]  RESET_PC       = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic [31:0] excp_target,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

    state_t      state;
    logic [31:0] tgt;
    logic [15:0] wd_cnt;
    logic [5:0]  prio_stall;

    always_comb begin
        prio_stall = 6'b000000;
        if (stallreq_mem)
            prio_stall = 6'b011111;
        else if (stallreq_ex)
            prio_stall = 6'b001111;
        else if (stallreq_id)
            prio_stall = 6'b000111;
        else if (stallreq_if)
            prio_stall = 6'b000011;
    end

    always_comb begin
        stall = 6'b000000;
        case (state)
            RUN:     stall = prio_stall;
            PEND:    stall = 6'b011111;
            default: stall = 6'b000000;
        endcase
    end

    // flush/new_pc are loaded on the edge that enters FLUSH, so they track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            flush  <= 1'b0;
            new_pc <= RESET_PC;
            tgt    <= 32'h0;
        end else begin
            flush <= 1'b0;
            case (state)
                RUN: begin
                    if (excp_valid) begin
                        tgt <= excp_target;
                        if (stallreq_mem) begin
                            state <= PEND;
                        end else begin
                            state  <= FLUSH;
                            flush  <= 1'b1;
                            new_pc <= excp_target;
                        end
                    end
                end
                PEND: begin
                    if (!stallreq_mem) begin
                        state  <= FLUSH;
                        flush  <= 1'b1;
                        new_pc <= tgt;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt        <= 16'd0;
            stall_timeout <= 1'b0;
        end else if (stall[0]) begin
            if (wd_cnt < TIMEOUT_W)
                wd_cnt <= wd_cnt + 16'd1;
            if (wd_cnt >= TIMEOUT_W - 16'd1)
                stall_timeout <= 1'b1;
        end else begin
            wd_cnt <= 16'd0;
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if (stall[0])
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
